// File: rtl/ifs_controller.sv
// CAN interframe-space controller.
// Follows the bus from end-of-frame/overload through intermission, suspend and
// idle. It also raises overload, start-of-frame and transmit-start pulses, and
// handles bus integration after power-up. All state changes happen on
// samplePoint strobes.
module ifs_controller #(
  parameter int INTERMISSION_BITS = 3,
  parameter int SUSPEND_BITS      = 8,
  parameter int IDLE_BITS         = 11,
  parameter int MAX_OVERLOAD      = 2,
  parameter int CNT_W             = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       samplePoint,
  input  logic       canRX,
  input  logic       frameEnd,
  input  logic       overloadEnd,
  input  logic       wasTransmitter,
  input  logic       errorPassive,
  input  logic       localOverloadReq,
  input  logic       txPending,
  output logic       isOverload,
  output logic       overloadLocal,
  output logic       isStart,
  output logic       txStart,
  output logic       protoErr,
  output logic       busIdle,
  output logic [2:0] ifsState,
  output logic [1:0] overloadCount
);

  typedef enum logic [2:0] {
    INTEGRATE    = 3'd0,
    BUSY         = 3'd1,
    INTERMISSION = 3'd2,
    SUSPEND      = 3'd3,
    IDLE         = 3'd4
  } state_t;

  typedef struct packed {
    logic ovl;
    logic ovl_local;
    logic start;
    logic tx_start;
    logic proto_err;
  } pulses_t;

  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_BITS - 1);
  localparam logic [CNT_W-1:0] IM_LAST    = CNT_W'(INTERMISSION_BITS - 1);
  localparam logic [CNT_W-1:0] SUSP_LAST  = CNT_W'(SUSPEND_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [1:0]       OVL_MAX    = 2'(MAX_OVERLOAD);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ovl_q, ovl_d;
  logic             txf_q, txf_d;
  pulses_t          pulse_q, pulse_d;

  // State, counters and output pulses all advance together on each clock.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= INTEGRATE;
      cnt_q   <= '0;
      ovl_q   <= '0;
      txf_q   <= 1'b0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovl_q   <= ovl_d;
      txf_q   <= txf_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state and pulse decode; evaluated only in strobe cycles.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    ovl_d   = ovl_q;
    txf_d   = txf_q;
    pulse_d = '0;

    if (samplePoint) begin
      if (state_q == INTEGRATE) begin
        if (!canRX) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else if (frameEnd) begin
        state_d = INTERMISSION;
        cnt_d   = '0;
        ovl_d   = '0;
        txf_d   = wasTransmitter;
      end else if (overloadEnd) begin
        state_d = INTERMISSION;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          INTERMISSION: begin
            if (localOverloadReq && cnt_q == '0 && ovl_q < OVL_MAX) begin
              pulse_d.ovl       = 1'b1;
              pulse_d.ovl_local = 1'b1;
              ovl_d             = ovl_q + 2'd1;
              state_d           = BUSY;
            end else if (!canRX) begin
              state_d = BUSY;
              if (cnt_q == IM_LAST) begin
                pulse_d.start = 1'b1;
              end else if (ovl_q < OVL_MAX) begin
                pulse_d.ovl = 1'b1;
                ovl_d       = ovl_q + 2'd1;
              end else begin
                pulse_d.proto_err = 1'b1;
              end
            end else if (cnt_q != IM_LAST) begin
              cnt_d = cnt_q + CNT_ONE;
            end else if (errorPassive && txf_q) begin
              state_d = SUSPEND;
              cnt_d   = '0;
            end else if (txPending) begin
              pulse_d.tx_start = 1'b1;
              state_d          = BUSY;
            end else begin
              state_d = IDLE;
            end
          end
          SUSPEND: begin
            if (!canRX) begin
              pulse_d.start = 1'b1;
              state_d       = BUSY;
            end else if (cnt_q == SUSP_LAST) begin
              if (txPending) begin
                pulse_d.tx_start = 1'b1;
                state_d          = BUSY;
              end else begin
                state_d = IDLE;
                txf_d   = 1'b0;
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          IDLE: begin
            if (!canRX) begin
              pulse_d.start = 1'b1;
              state_d       = BUSY;
            end else if (txPending) begin
              pulse_d.tx_start = 1'b1;
              state_d          = BUSY;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign isOverload    = pulse_q.ovl;
  assign overloadLocal = pulse_q.ovl_local;
  assign isStart       = pulse_q.start;
  assign txStart       = pulse_q.tx_start;
  assign protoErr      = pulse_q.proto_err;
  assign busIdle       = (state_q == IDLE);
  assign ifsState      = state_q;
  assign overloadCount = ovl_q;

endmodule

// File: tb/tb_ifs_controller.sv
// Bench for ifs_controller: directed scenarios plus a randomized run checked
// against a behavioural model of the interframe space.
module tb_ifs_controller;
  localparam int IB   = 3;
  localparam int SB   = 8;
  localparam int IDB  = 11;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic rst, samplePoint, canRX, frameEnd, overloadEnd, wasTransmitter;
  logic errorPassive, localOverloadReq, txPending;
  logic isOverload, overloadLocal, isStart, txStart, protoErr, busIdle;
  logic [2:0] ifsState;
  logic [1:0] overloadCount;

  int n_checks = 0;
  int n_fail   = 0;

  ifs_controller #(
    .INTERMISSION_BITS(IB), .SUSPEND_BITS(SB), .IDLE_BITS(IDB),
    .MAX_OVERLOAD(MAXO), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .samplePoint(samplePoint), .canRX(canRX),
    .frameEnd(frameEnd), .overloadEnd(overloadEnd),
    .wasTransmitter(wasTransmitter), .errorPassive(errorPassive),
    .localOverloadReq(localOverloadReq), .txPending(txPending),
    .isOverload(isOverload), .overloadLocal(overloadLocal),
    .isStart(isStart), .txStart(txStart), .protoErr(protoErr),
    .busIdle(busIdle), .ifsState(ifsState), .overloadCount(overloadCount)
  );

  always #5 clk = ~clk;

  // Behavioural model: the bus is integrating, busy, inside the interframe
  // space (one position counted from end of frame across intermission and
  // suspend), or idle.
  localparam int M_INTEG = 10, M_BUSY = 11, M_IFS = 12, M_IDLE = 13;
  int m_mode = M_INTEG;
  int m_run  = 0;
  int m_pos  = 0;
  int m_ovl  = 0;
  bit m_txf  = 1'b0;
  bit e_ovl, e_loc, e_start, e_txs, e_perr;

  function automatic void model_step(input logic r, sp, rx, fe, oe, wt, ep, lo, tp);
    e_ovl = 0; e_loc = 0; e_start = 0; e_txs = 0; e_perr = 0;
    if (r) begin
      m_mode = M_INTEG; m_run = 0; m_pos = 0; m_ovl = 0; m_txf = 0;
      return;
    end
    if (!sp) return;
    if (m_mode == M_INTEG) begin
      if (rx) begin
        m_run++;
        if (m_run == IDB) begin m_mode = M_IDLE; m_run = 0; end
      end else m_run = 0;
      return;
    end
    if (fe) begin m_mode = M_IFS; m_pos = 0; m_ovl = 0; m_txf = wt; return; end
    if (oe) begin m_mode = M_IFS; m_pos = 0; return; end
    if (m_mode == M_IFS && m_pos < IB) begin
      if (lo && m_pos == 0 && m_ovl < MAXO) begin
        e_ovl = 1; e_loc = 1; m_ovl++; m_mode = M_BUSY;
      end else if (!rx) begin
        m_mode = M_BUSY;
        if (m_pos == IB - 1) e_start = 1;
        else if (m_ovl < MAXO) begin e_ovl = 1; m_ovl++; end
        else e_perr = 1;
      end else if (m_pos < IB - 1 || (ep && m_txf)) begin
        m_pos++;
      end else if (tp) begin
        e_txs = 1; m_mode = M_BUSY;
      end else m_mode = M_IDLE;
    end else if (m_mode == M_IFS) begin
      if (!rx) begin
        e_start = 1; m_mode = M_BUSY;
      end else if (m_pos == IB + SB - 1) begin
        if (tp) begin e_txs = 1; m_mode = M_BUSY; end
        else begin m_mode = M_IDLE; m_txf = 0; end
      end else m_pos++;
    end else if (m_mode == M_IDLE) begin
      if (!rx) begin e_start = 1; m_mode = M_BUSY; end
      else if (tp) begin e_txs = 1; m_mode = M_BUSY; end
    end
  endfunction

  function automatic logic [2:0] model_state();
    case (m_mode)
      M_INTEG: return 3'd0;
      M_BUSY:  return 3'd1;
      M_IFS:   return (m_pos < IB) ? 3'd2 : 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [10:0] model_vec();
    return {e_ovl, e_loc, e_start, e_txs, e_perr, logic'(m_mode == M_IDLE),
            model_state(), 2'(m_ovl)};
  endfunction

  function automatic logic [10:0] obs();
    return {isOverload, overloadLocal, isStart, txStart, protoErr, busIdle,
            ifsState, overloadCount};
  endfunction

  function automatic logic [10:0] ev(input logic o, l, s, t, p, i,
                                     input logic [2:0] st, input logic [1:0] c);
    return {o, l, s, t, p, i, st, c};
  endfunction

  // One clock: drive inputs, step the model at the edge, return at negedge.
  task automatic tick(input logic r, sp, rx, fe, oe, wt, ep, lo, tp);
    rst = r; samplePoint = sp; canRX = rx; frameEnd = fe; overloadEnd = oe;
    wasTransmitter = wt; errorPassive = ep; localOverloadReq = lo; txPending = tp;
    @(posedge clk);
    model_step(r, sp, rx, fe, oe, wt, ep, lo, tp);
    @(negedge clk);
  endtask

  task automatic strobe(input logic rx, fe, oe, wt, ep, lo, tp);
    tick(1'b0, 1'b1, rx, fe, oe, wt, ep, lo, tp);
  endtask

  task automatic quiet();
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    logic [10:0] want;
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    want = ev(0, 0, 0, 0, 0, 0, 3'd0, 2'd0);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL reset_state: got %b want %b", obs(), want); end
  endtask

  task automatic test_integration();
    logic [10:0] want;
    for (int i = 0; i < 5; i++) begin strobe(1, 0, 0, 0, 0, 0, 0); repeat (3) quiet(); end
    strobe(0, 0, 0, 0, 0, 0, 0); repeat (3) quiet();
    for (int i = 0; i < 10; i++) begin strobe(1, 0, 0, 0, 0, 0, 0); repeat (3) quiet(); end
    want = ev(0, 0, 0, 0, 0, 0, 3'd0, 2'd0);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL integ_10th: got %b want %b", obs(), want); end
    strobe(1, 0, 0, 0, 0, 0, 0);
    want = ev(0, 0, 0, 0, 0, 1, 3'd4, 2'd0);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL integ_11th: got %b want %b", obs(), want); end
  endtask

  task automatic test_overload_limit();
    logic [10:0] want;
    strobe(1, 1, 0, 0, 0, 0, 0);
    strobe(1, 0, 0, 0, 0, 0, 0);
    strobe(0, 0, 0, 0, 0, 0, 0);
    want = ev(1, 0, 0, 0, 0, 0, 3'd1, 2'd1);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL ovl_first: got %b want %b", obs(), want); end
    quiet();
    want = ev(0, 0, 0, 0, 0, 0, 3'd1, 2'd1);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL ovl_one_clk: got %b want %b", obs(), want); end
    strobe(1, 0, 1, 0, 0, 0, 0);
    strobe(0, 0, 0, 0, 0, 0, 0);
    want = ev(1, 0, 0, 0, 0, 0, 3'd1, 2'd2);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL ovl_second: got %b want %b", obs(), want); end
    strobe(1, 0, 1, 0, 0, 0, 0);
    strobe(0, 0, 0, 0, 0, 0, 0);
    want = ev(0, 0, 0, 0, 1, 0, 3'd1, 2'd2);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL ovl_limit: got %b want %b", obs(), want); end
  endtask

  task automatic test_sof();
    logic [10:0] want;
    strobe(1, 1, 0, 0, 0, 0, 0);
    strobe(1, 0, 0, 0, 0, 0, 0);
    strobe(1, 0, 0, 0, 0, 0, 0);
    strobe(0, 0, 0, 0, 0, 0, 0);
    want = ev(0, 0, 1, 0, 0, 0, 3'd1, 2'd0);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL sof_pulse: got %b want %b", obs(), want); end
    quiet();
    want = ev(0, 0, 0, 0, 0, 0, 3'd1, 2'd0);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL sof_one_clk: got %b want %b", obs(), want); end
  endtask

  task automatic test_suspend();
    logic [10:0] want;
    strobe(1, 1, 0, 1, 1, 0, 1);
    for (int i = 1; i <= 10; i++) begin
      strobe(1, 0, 0, 0, 1, 0, 1);
      want = ev(0, 0, 0, 0, 0, 0, (i < 3) ? 3'd2 : 3'd3, 2'd0);
      n_checks++;
      if (obs() !== want) begin n_fail++; $display("FAIL susp_tx_strobe%0d: got %b want %b", i, obs(), want); end
    end
    strobe(1, 0, 0, 0, 1, 0, 1);
    want = ev(0, 0, 0, 1, 0, 0, 3'd1, 2'd0);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL susp_txstart: got %b want %b", obs(), want); end
    strobe(1, 1, 0, 1, 1, 0, 0);
    repeat (10) strobe(1, 0, 0, 0, 1, 0, 0);
    want = ev(0, 0, 0, 0, 0, 0, 3'd3, 2'd0);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL susp_idle_10th: got %b want %b", obs(), want); end
    strobe(1, 0, 0, 0, 1, 0, 0);
    want = ev(0, 0, 0, 0, 0, 1, 3'd4, 2'd0);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL susp_idle_11th: got %b want %b", obs(), want); end
  endtask

  task automatic test_local_overload();
    logic [10:0] want;
    strobe(1, 1, 0, 0, 0, 0, 0);
    strobe(1, 0, 0, 0, 0, 1, 0);
    want = ev(1, 1, 0, 0, 0, 0, 3'd1, 2'd1);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL local_first: got %b want %b", obs(), want); end
    strobe(1, 1, 0, 0, 0, 0, 0);
    strobe(1, 0, 0, 0, 0, 0, 0);
    strobe(1, 0, 0, 0, 0, 1, 0);
    want = ev(0, 0, 0, 0, 0, 0, 3'd2, 2'd0);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL local_ignored: got %b want %b", obs(), want); end
    strobe(0, 0, 0, 0, 0, 0, 0);
    want = ev(0, 0, 1, 0, 0, 0, 3'd1, 2'd0);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL local_cnt2_sof: got %b want %b", obs(), want); end
  endtask

  task automatic test_idle_reset();
    logic [10:0] want;
    strobe(1, 1, 0, 0, 0, 0, 0);
    repeat (3) strobe(1, 0, 0, 0, 0, 0, 0);
    want = ev(0, 0, 0, 0, 0, 1, 3'd4, 2'd0);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL idle_reached: got %b want %b", obs(), want); end
    strobe(0, 0, 0, 0, 0, 0, 1);
    want = ev(0, 0, 1, 0, 0, 0, 3'd1, 2'd0);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL idle_dom_wins: got %b want %b", obs(), want); end
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    want = ev(0, 0, 0, 0, 0, 0, 3'd0, 2'd0);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL rst_in_busy: got %b want %b", obs(), want); end
    repeat (11) strobe(1, 0, 0, 0, 0, 0, 0);
    strobe(1, 1, 0, 0, 0, 0, 0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    want = ev(0, 0, 0, 0, 0, 0, 3'd0, 2'd0);
    n_checks++;
    if (obs() !== want) begin n_fail++; $display("FAIL rst_suppress: got %b want %b", obs(), want); end
  endtask

  task automatic test_random();
    logic [10:0] want;
    logic r, sp, rx, fe, oe, wt, ep, lo, tp;
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 399) == 0);
      sp = 1'($urandom_range(0, 1));
      rx = ($urandom_range(0, 15) != 0);
      fe = ($urandom_range(0, 11) == 0);
      oe = ($urandom_range(0, 15) == 0);
      wt = 1'($urandom_range(0, 1));
      ep = 1'($urandom_range(0, 1));
      lo = ($urandom_range(0, 5) == 0);
      tp = ($urandom_range(0, 2) == 0);
      tick(r, sp, rx, fe, oe, wt, ep, lo, tp);
      want = model_vec();
      n_checks++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %b want %b", i, obs(), want);
      end
    end
  endtask

  initial begin
    rst = 1'b1; samplePoint = 1'b0; canRX = 1'b1; frameEnd = 1'b0;
    overloadEnd = 1'b0; wasTransmitter = 1'b0; errorPassive = 1'b0;
    localOverloadReq = 1'b0; txPending = 1'b0;
    @(negedge clk);
    test_reset();
    test_integration();
    test_overload_limit();
    test_sof();
    test_suspend();
    test_local_overload();
    test_idle_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
